math_pipelined_sequencer: RTL and testbench

Valid/ready front-end for the pipelined add/sub/gate unit (math_pipelined).
- Accepts one operand pair per transaction and issues it to the unit with a single-cycle `math_ce` strobe.
- Holds the operands stable for the unit's full latency, then captures sum/sub/and/or/xor into a result register.
- Presents the result downstream with valid/ready backpressure.
- One operation in flight; sits between the stream producer and the math unit, which is instantiated alongside with the same WIDTH/LATENCY.

---
 rtl/math_pipelined_sequencer.sv | 97 +++++++++
 tb/tb_math_pipelined_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_pipelined_sequencer.sv
// Valid/ready front-end for the pipelined add/sub/gate unit: issues one operand
// pair with a single-cycle math_ce, waits out the unit latency, then holds the result.
module math_pipelined_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_sub,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic             busy,
  output logic             math_ce,
  output logic [WIDTH-1:0] math_i1,
  output logic [WIDTH-1:0] math_i2,
  input  logic [WIDTH-1:0] math_sum,
  input  logic [WIDTH-1:0] math_sub,
  input  logic             math_and,
  input  logic             math_or,
  input  logic             math_xor
);

  localparam int unsigned   CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign math_ce  = (state == ISSUE);
  assign busy     = (state == ISSUE) || (state == WAIT);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The operand registers double as math_i1/math_i2, so they only move on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      math_i1   <= '0;
      math_i2   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sub   <= '0;
      out_and   <= 1'b0;
      out_or    <= 1'b0;
      out_xor   <= 1'b0;
    end else begin
      if (accept) begin
        math_i1 <= in_a;
        math_i2 <= in_b;
      end
      if (state == ISSUE) begin
        cnt <= CW'(1);
      end else if (state == WAIT) begin
        if (cnt != CNT_LAST) begin
          cnt <= cnt + CW'(1);
        end else begin
          out_sum   <= math_sum;
          out_sub   <= math_sub;
          out_and   <= math_and;
          out_or    <= math_or;
          out_xor   <= math_xor;
          out_valid <= 1'b1;
        end
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_math_pipelined_sequencer.sv
// Scoreboard bench: two sequencer instances (W8/L4 and W4/L1), each driving a
// behavioural math unit whose outputs are only correct in the exact capture slot.
module tb_math_pipelined_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         acc;
  } op_t;

  function automatic logic [18:0] ref8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] s, d;
    s = x + y;
    d = x - y;
    return {s, d, &{x, y}, |{x, y}, ^{x, y}};
  endfunction

  function automatic logic [10:0] ref4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] s, d;
    s = x + y;
    d = x - y;
    return {s, d, &{x, y}, |{x, y}, ^{x, y}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- instance A: WIDTH=8, LATENCY=4 ----------------
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_ce;
  logic [7:0] a_in_a, a_in_b, a_sum, a_sub, a_mi1, a_mi2, a_msum, a_msub;
  logic       a_and, a_or, a_xor, a_mand, a_mor, a_mxor;

  math_pipelined_sequencer #(.WIDTH(8), .LATENCY(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_b(a_in_b),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_sum), .out_sub(a_sub), .out_and(a_and), .out_or(a_or), .out_xor(a_xor),
    .busy(a_busy), .math_ce(a_ce), .math_i1(a_mi1), .math_i2(a_mi2),
    .math_sum(a_msum), .math_sub(a_msub), .math_and(a_mand), .math_or(a_mor), .math_xor(a_mxor)
  );

  // Math unit: valid result appears LATENCY-1 edges after the edge sampling ce, noise otherwise.
  logic [18:0] a_pipe [4];
  always @(posedge clk) begin
    a_pipe[0] <= a_ce ? ref8(a_mi1, a_mi2) : 19'($urandom);
    for (int k = 1; k < 4; k++) a_pipe[k] <= a_pipe[k-1];
  end
  assign {a_msum, a_msub, a_mand, a_mor, a_mxor} = a_pipe[3];

  op_t         a_q[$];
  int          a_acc_hist[$];
  logic [7:0]  a_cur_a, a_cur_b;
  int          a_last_acc = -10;
  logic        a_prev_ov = 1'b0;
  logic [18:0] a_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete();
      a_prev_ov = 1'b0;
    end else begin
      if (a_ce) chk("a_ce_cycle", cyc, a_last_acc);
      if (a_busy) begin
        chk("a_i1_hold", a_mi1, a_cur_a);
        chk("a_i2_hold", a_mi2, a_cur_b);
      end
      if (a_out_valid) begin
        if (a_q.size() == 0) chk("a_unexpected_out", a_out_valid, 0);
        else begin
          a_exp = ref8(a_q[0].a, a_q[0].b);
          chk("a_result", {a_sum, a_sub, a_and, a_or, a_xor}, a_exp);
          if (!a_prev_ov) chk("a_latency", cyc - a_q[0].acc, 5);
          if (a_out_ready) void'(a_q.pop_front());
          else chk("a_stall_in_ready", a_in_ready, 0);
        end
      end
      a_prev_ov = a_out_valid;
      if (a_in_valid && a_in_ready) begin
        a_q.push_back('{a_in_a, a_in_b, cyc + 1});
        a_acc_hist.push_back(cyc + 1);
        a_cur_a    = a_in_a;
        a_cur_b    = a_in_b;
        a_last_acc = cyc + 1;
      end
    end
  end

  // ---------------- instance B: WIDTH=4, LATENCY=1 ----------------
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_ce;
  logic [3:0] b_in_a, b_in_b, b_sum, b_sub, b_mi1, b_mi2, b_msum, b_msub;
  logic       b_and, b_or, b_xor, b_mand, b_mor, b_mxor;

  math_pipelined_sequencer #(.WIDTH(4), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_sum), .out_sub(b_sub), .out_and(b_and), .out_or(b_or), .out_xor(b_xor),
    .busy(b_busy), .math_ce(b_ce), .math_i1(b_mi1), .math_i2(b_mi2),
    .math_sum(b_msum), .math_sub(b_msub), .math_and(b_mand), .math_or(b_mor), .math_xor(b_mxor)
  );

  logic [10:0] b_pipe;
  always @(posedge clk) b_pipe <= b_ce ? ref4(b_mi1, b_mi2) : 11'($urandom);
  assign {b_msum, b_msub, b_mand, b_mor, b_mxor} = b_pipe;

  op_t         b_q[$];
  int          b_last_acc = -10;
  logic        b_prev_ov = 1'b0;
  logic [10:0] b_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_q.delete();
      b_prev_ov = 1'b0;
    end else begin
      if (b_ce) chk("b_ce_cycle", cyc, b_last_acc);
      if (b_out_valid) begin
        if (b_q.size() == 0) chk("b_unexpected_out", b_out_valid, 0);
        else begin
          b_exp = ref4(b_q[0].a[3:0], b_q[0].b[3:0]);
          chk("b_result", {b_sum, b_sub, b_and, b_or, b_xor}, b_exp);
          if (!b_prev_ov) chk("b_latency", cyc - b_q[0].acc, 2);
          if (b_out_ready) void'(b_q.pop_front());
          else chk("b_stall_in_ready", b_in_ready, 0);
        end
      end
      b_prev_ov = b_out_valid;
      if (b_in_valid && b_in_ready) begin
        b_q.push_back('{{4'h0, b_in_a}, {4'h0, b_in_b}, cyc + 1});
        b_last_acc = cyc + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] x, input logic [7:0] y);
    int t = 0;
    a_in_valid = 1'b1;
    a_in_a = x;
    a_in_b = y;
    while (!a_in_ready && t < 100) begin step(); t++; end
    if (t >= 100) chk("a_send_timeout", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    a_in_a = 8'($urandom);
    a_in_b = 8'($urandom);
  endtask

  task automatic b_send(input logic [3:0] x, input logic [3:0] y);
    int t = 0;
    b_in_valid = 1'b1;
    b_in_a = x;
    b_in_b = y;
    while (!b_in_ready && t < 100) begin step(); t++; end
    if (t >= 100) chk("b_send_timeout", b_in_ready, 1);
    step();
    b_in_valid = 1'b0;
    b_in_a = 4'($urandom);
    b_in_b = 4'($urandom);
  endtask

  task automatic a_wait_out();
    int t = 0;
    @(negedge clk);
    while (!a_out_valid && t < 50) begin @(negedge clk); t++; end
    chk("a_out_timeout", a_out_valid, 1);
  endtask

  task automatic b_wait_out();
    int t = 0;
    @(negedge clk);
    while (!b_out_valid && t < 50) begin @(negedge clk); t++; end
    chk("b_out_timeout", b_out_valid, 1);
  endtask

  task automatic drain();
    int t = 0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    while ((a_q.size() != 0 || b_q.size() != 0) && t < 200) begin step(); t++; end
    chk("drain_a", a_q.size(), 0);
    chk("drain_b", b_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, k, t, acc;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_out_ready = 1'b0;
    #3;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_ce", a_ce, 0);
    chk("rst_a_i1", a_mi1, 0);
    chk("rst_a_sum", a_sum, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Directed results with downstream always ready.
    a_out_ready = 1'b1;
    a_send(8'hF0, 8'h1F);
    a_wait_out();
    chk("a_f0_sum", a_sum, 8'h0F);
    chk("a_f0_sub", a_sub, 8'hD1);
    chk("a_f0_gates", {a_and, a_or, a_xor}, 3'b011);
    a_send(8'h00, 8'h01);
    a_wait_out();
    chk("a_borrow_sub", a_sub, 8'hFF);
    chk("a_borrow_sum", a_sum, 8'h01);
    chk("a_borrow_gates", {a_and, a_or, a_xor}, 3'b011);

    // Stall, then consume and accept on the same edge.
    step();
    a_out_ready = 1'b0;
    a_send(8'hFF, 8'hFF);
    a_wait_out();
    chk("a_ff_sum", a_sum, 8'hFE);
    chk("a_ff_sub", a_sub, 8'h00);
    chk("a_ff_gates", {a_and, a_or, a_xor}, 3'b110);
    step();
    repeat (10) step();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_a = 8'h12; a_in_b = 8'h34;
    @(negedge clk);
    chk("a_done_in_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    chk("a_reissue_busy", a_busy, 1);
    chk("a_consumed_valid", a_out_valid, 0);
    drain();

    // Back-to-back accepts with both handshakes held high.
    n0 = a_acc_hist.size();
    k = n0;
    t = 0;
    a_in_a = 8'($urandom); a_in_b = 8'($urandom); a_in_valid = 1'b1;
    while (a_acc_hist.size() < n0 + 6 && t < 100) begin
      step(); t++;
      if (a_acc_hist.size() != k) begin
        k = a_acc_hist.size();
        a_in_a = 8'($urandom); a_in_b = 8'($urandom);
      end
    end
    a_in_valid = 1'b0;
    chk("a_b2b_count", a_acc_hist.size(), n0 + 6);
    for (int i = n0 + 1; i < a_acc_hist.size(); i++)
      chk("a_b2b_spacing", a_acc_hist[i] - a_acc_hist[i-1], 6);
    drain();

    // Randomized traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      a_in_valid = 1'($urandom); a_in_a = 8'($urandom); a_in_b = 8'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid = 1'($urandom); b_in_a = 4'($urandom); b_in_b = 4'($urandom);
      b_out_ready = 1'($urandom);
      step();
    end
    drain();

    // Reset in the middle of WAIT discards the operation.
    a_send(8'h55, 8'hAA);
    acc = a_last_acc;
    while (cyc < acc + 3) step();
    chk("a_pre_reset_busy", a_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("a_async_ce", a_ce, 0);
    chk("a_async_busy", a_busy, 0);
    chk("a_async_out_valid", a_out_valid, 0);
    repeat (2) step();
    #1 rst_n = 1'b1;
    repeat (12) step();
    chk("a_post_reset_in_ready", a_in_ready, 1);
    chk("a_post_reset_busy", a_busy, 0);
    chk("a_post_reset_out_valid", a_out_valid, 0);

    // LATENCY=1 instance.
    b_out_ready = 1'b1;
    b_send(4'h9, 4'h8);
    b_wait_out();
    chk("b_98_sum", b_sum, 4'h1);
    chk("b_98_sub", b_sub, 4'h1);
    for (int i = 0; i < 150; i++) begin
      b_in_valid = 1'($urandom); b_in_a = 4'($urandom); b_in_b = 4'($urandom);
      b_out_ready = 1'($urandom);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
